// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command and response encodings plus the request-adapter state type.
package calc1_pkg;

    localparam int unsigned CMD_NOP = 0;
    localparam int unsigned CMD_ADD = 1;
    localparam int unsigned CMD_SUB = 2;
    localparam int unsigned CMD_SHL = 5;
    localparam int unsigned CMD_SHR = 6;

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } adapter_state_e;

endpackage

// File: rtl/calc1_req_adapter.sv
// Front-end for one calc1 request port: serialises a single-beat command onto the
// two-cycle calc1 pin protocol, waits for the response with a timeout and holds the result.
module calc1_req_adapter
    import calc1_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [1:0]        calc_resp,
    input  logic [DATA_W-1:0] calc_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              spurious_resp
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    adapter_state_e    state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] op2_reg;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            op2_reg       <= '0;
            in_ready      <= 1'b1;
            req_cmd_out   <= '0;
            req_data_out  <= '0;
            rsp_valid     <= 1'b0;
            rsp_code      <= RESP_NONE;
            rsp_data      <= '0;
            spurious_resp <= 1'b0;
        end else begin
            // Any response code seen outside WAIT is flagged and otherwise ignored.
            spurious_resp <= (calc_resp != RESP_NONE) && (state_reg != ST_WAIT);

            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        op2_reg  <= in_op2;
                        if (in_cmd != CMD_W'(CMD_NOP)) begin
                            state_reg    <= ST_SEND1;
                            req_cmd_out  <= in_cmd;
                            req_data_out <= in_op1;
                        end else begin
                            // NOP never reaches calc1; answer it locally as invalid.
                            state_reg <= ST_HOLD;
                            rsp_valid <= 1'b1;
                            rsp_code  <= RESP_ERR;
                            rsp_data  <= '0;
                        end
                    end
                end
                ST_SEND1: begin
                    state_reg    <= ST_SEND2;
                    req_cmd_out  <= '0;
                    req_data_out <= op2_reg;
                end
                ST_SEND2: begin
                    state_reg    <= ST_WAIT;
                    req_data_out <= '0;
                    cnt_reg      <= '0;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // A response in the final counted cycle still beats the timeout.
                    if (calc_resp != RESP_NONE) begin
                        state_reg <= ST_HOLD;
                        rsp_valid <= 1'b1;
                        rsp_code  <= calc_resp;
                        rsp_data  <= (calc_resp == RESP_OK) ? calc_data : '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_HOLD;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RESP_TIMEOUT;
                        rsp_data  <= '0;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    in_ready  <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_adapter.sv
// Directed bench for calc1_req_adapter with a small calc1 stub driven from the observed pins.
module tb_calc1_req_adapter;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          c_clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_cmd = '0;
    logic [DW-1:0] in_op1 = '0;
    logic [DW-1:0] in_op2 = '0;
    logic [CW-1:0] req_cmd_out;
    logic [DW-1:0] req_data_out;
    logic [1:0]    calc_resp = '0;
    logic [DW-1:0] calc_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_code;
    logic [DW-1:0] rsp_data;
    logic          spurious_resp;

    calc1_req_adapter #(.DATA_W(DW), .CMD_W(CW), .TIMEOUT(TO)) dut (
        .c_clk(c_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .calc_resp(calc_resp), .calc_data(calc_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_code(rsp_code), .rsp_data(rsp_data),
        .spurious_resp(spurious_resp)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int          lat;
        int          hold;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent calc1 behaviour: overflow/underflow and unknown commands are errors.
    function automatic void stub(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [1:0] code, output logic [31:0] d);
        logic [32:0] s;
        code = 2'd2;
        d    = 32'hBAD0_BAD0;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[32]) begin code = 2'd1; d = s[31:0]; end
            end
            4'd2: if (a >= b) begin code = 2'd1; d = a - b; end
            4'd5: begin code = 2'd1; d = a << b[4:0]; end
            4'd6: begin code = 2'd1; d = a >> b[4:0]; end
            default: ;
        endcase
    endfunction

    task automatic handshake(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_cmd   = c;
        in_op1   = a;
        in_op2   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_hold(input string n);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({n, ".in_ready_after"}, 32'(in_ready), 32'd1);
        chk({n, ".rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic run(input vec_t v, input int idx);
        string       n;
        logic [3:0]  pin_cmd;
        logic [31:0] pin_op1, pin_op2;
        logic [1:0]  sc;
        logic [31:0] sd;
        n = $sformatf("v%0d", idx);
        chk({n, ".in_ready"}, 32'(in_ready), 32'd1);
        handshake(v.cmd, v.op1, v.op2);
        chk({n, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        if (v.cmd != 4'd0) begin
            pin_cmd = req_cmd_out;
            pin_op1 = req_data_out;
            chk({n, ".send1_cmd"}, 32'(req_cmd_out), 32'(v.cmd));
            chk({n, ".send1_data"}, req_data_out, v.op1);
            tick();
            pin_op2 = req_data_out;
            chk({n, ".send2_cmd"}, 32'(req_cmd_out), 32'd0);
            chk({n, ".send2_data"}, req_data_out, v.op2);
            tick();
            chk({n, ".wait_cmd"}, 32'(req_cmd_out), 32'd0);
            chk({n, ".wait_data"}, req_data_out, 32'd0);
            stub(pin_cmd, pin_op1, pin_op2, sc, sd);
            for (int i = 0; i < v.lat; i++) begin
                tick();
                chk({n, ".wait_valid"}, 32'(rsp_valid), 32'd0);
            end
            calc_resp = sc;
            calc_data = sd;
            tick();
            calc_resp = 2'd0;
            calc_data = '0;
        end else begin
            chk({n, ".nop_cmd"}, 32'(req_cmd_out), 32'd0);
        end
        chk({n, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({n, ".rsp_code"}, 32'(rsp_code), 32'(v.exp_code));
        chk({n, ".rsp_data"}, rsp_data, v.exp_data);
        for (int i = 0; i < v.hold; i++) begin
            if (i == 0) calc_resp = 2'd2;
            tick();
            calc_resp = 2'd0;
            if (i == 0) chk({n, ".hold_spurious"}, 32'(spurious_resp), 32'd1);
            chk({n, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({n, ".hold_code"}, 32'(rsp_code), 32'(v.exp_code));
            chk({n, ".hold_data"}, rsp_data, v.exp_data);
            chk({n, ".hold_cmd"}, 32'(req_cmd_out), 32'd0);
            chk({n, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        $display("txn %0d cmd=%0d op1=%h op2=%h code=%0d data=%h", idx, v.cmd, v.op1, v.op2,
                 rsp_code, rsp_data);
        release_hold(n);
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({n, ".req_cmd"}, 32'(req_cmd_out), 32'd0);
        chk({n, ".req_data"}, req_data_out, 32'd0);
        chk({n, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({n, ".rsp_code"}, 32'(rsp_code), 32'd0);
        chk({n, ".rsp_data"}, rsp_data, 32'd0);
        chk({n, ".spurious"}, 32'(spurious_resp), 32'd0);
    endtask

    // Assert reset a few ns into the cycle that is ticks_after edges past the handshake.
    task automatic mid_reset(input string n, input logic [3:0] c, input int ticks_after);
        handshake(c, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < ticks_after; i++) tick();
        #1 reset = 1'b1;
        #1 chk_reset_vals(n);
        tick();
        reset = 1'b0;
        $display("txn reset %s cmd=%0d after=%0d", n, c, ticks_after);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2,  0, 2'd1, 32'h0200_0000};
        vecs[1] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0,  0, 2'd2, 32'h0};
        vecs[2] = '{4'd0, 32'h0000_0005, 32'h0000_0007, 0,  2, 2'd2, 32'h0};
        vecs[3] = '{4'd2, 32'h0000_0001, 32'h0000_000F, 3,  5, 2'd2, 32'h0};
        vecs[4] = '{4'd2, 32'h0000_0010, 32'h0000_0003, 1,  1, 2'd1, 32'h0000_000D};
        vecs[5] = '{4'd5, 32'h0000_0003, 32'h0000_0004, 15, 0, 2'd1, 32'h0000_0030};
        vecs[6] = '{4'd6, 32'h8000_0000, 32'h0000_001F, 4,  2, 2'd1, 32'h0000_0001};
        vecs[7] = '{4'd7, 32'h0000_0001, 32'h0000_0002, 1,  0, 2'd2, 32'h0};

        repeat (2) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run(vecs[i], i);

        // Spurious response while idle.
        calc_resp = 2'd1;
        calc_data = 32'hFFFF_FFFF;
        tick();
        calc_resp = 2'd0;
        calc_data = '0;
        chk("idle_spurious", 32'(spurious_resp), 32'd1);
        chk("idle_spurious_ready", 32'(in_ready), 32'd1);
        chk("idle_spurious_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("idle_spurious_pulse", 32'(spurious_resp), 32'd0);
        $display("txn spurious idle");

        // Silent calc1: timeout exactly TO cycles after WAIT entry.
        handshake(4'd1, 32'h1, 32'h2);
        tick();
        tick();
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TO));
        chk("timeout_code", 32'(rsp_code), 32'd3);
        chk("timeout_data", rsp_data, 32'd0);
        $display("txn timeout cycles=%0d code=%0d", n, rsp_code);
        release_hold("timeout");

        mid_reset("rst_send1", 4'd1, 0);
        mid_reset("rst_wait", 4'd1, 5);
        mid_reset("rst_hold", 4'd0, 0);

        run('{4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2, 1, 2'd1, 32'h3FFF_FFFE}, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
